dff_arbiter: RTL and testbench

DFF_ARBITER -- requirements
Module: dff_arbiter

---
 rtl/dff_arb_pkg.sv | 15 +
 rtl/dff_en_reg.sv | 20 ++
 rtl/dff_arbiter.sv | 151 +++++++++++++++
 tb/tb_dff_arbiter.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/dff_arb_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
// FSM state encoding and default configuration constants.
package dff_arb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GRANT   = 2'd1,
        RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_N_REQ   = 4;
    localparam int DEF_WIDTH   = 8;
    localparam int DEF_TIMEOUT = 16;

endpackage

// File: rtl/dff_en_reg.sv
// WIDTH-wide register with load enable and asynchronous active-low clear.
module dff_en_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/dff_arbiter.sv
// Round-robin arbiter guarding one shared register written by the current grantee.
// Optional forced release after TIMEOUT grant cycles: define DFF_ARB_TIMEOUT_EN.
module dff_arbiter
    import dff_arb_pkg::*;
#(
    parameter int N_REQ   = DEF_N_REQ,
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [N_REQ-1:0]         wr_en,
    input  logic [N_REQ*WIDTH-1:0]   wr_data,
    output logic [N_REQ-1:0]         grant,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     busy,
    output logic [WIDTH-1:0]         q,
    output logic                     q_valid,
    output logic                     timeout
);

    localparam int OW = $clog2(N_REQ);

    if (N_REQ < 2 || N_REQ > 8 || TIMEOUT < 1) begin : g_bad_param
        $error("dff_arbiter: N_REQ must be 2..8 and TIMEOUT >= 1");
    end

    arb_state_t       state_reg, state_next;
    logic [N_REQ-1:0] grant_reg, grant_next;
    logic [OW-1:0]    owner_reg, owner_next;
    logic [OW-1:0]    rr_ptr_reg, rr_ptr_next;
    logic             q_valid_reg;
    logic             found;
    logic [OW-1:0]    win;
    int               idx;
    logic             expire;
    logic             load;
    logic [WIDTH-1:0] wr_slice [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
        assign wr_slice[gi] = wr_data[gi*WIDTH +: WIDTH];
    end

    // First requester at or after the pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < N_REQ; k++) begin
            idx = (int'(rr_ptr_reg) + k) % N_REQ;
            if (!found && req[idx]) begin
                found = 1'b1;
                win   = OW'(idx);
            end
        end
    end

    always_comb begin
        state_next  = state_reg;
        grant_next  = grant_reg;
        owner_next  = owner_reg;
        rr_ptr_next = rr_ptr_reg;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    state_next      = GRANT;
                    grant_next      = '0;
                    grant_next[win] = 1'b1;
                    owner_next      = win;
                    rr_ptr_next     = (win == OW'(N_REQ - 1)) ? '0 : win + 1'b1;
                end
            end
            GRANT: begin
                if (!req[owner_reg] || expire) begin
                    state_next = RELEASE;
                    grant_next = '0;
                    owner_next = '0;
                end
            end
            RELEASE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg   <= IDLE;
            grant_reg   <= '0;
            owner_reg   <= '0;
            rr_ptr_reg  <= '0;
            q_valid_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            grant_reg  <= grant_next;
            owner_reg  <= owner_next;
            rr_ptr_reg <= rr_ptr_next;
            if (load) begin
                q_valid_reg <= 1'b1;
            end
        end
    end

`ifdef DFF_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);

    // hold_cnt_reg holds the 1-based index of the current grant cycle.
    logic [CW-1:0] hold_cnt_reg;
    logic          timeout_reg;

    assign expire = (state_reg == GRANT) && (hold_cnt_reg == CW'(TIMEOUT));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_cnt_reg <= '0;
            timeout_reg  <= 1'b0;
        end else begin
            timeout_reg <= expire;
            if (state_next == GRANT) begin
                hold_cnt_reg <= (state_reg == GRANT) ? hold_cnt_reg + 1'b1 : CW'(1);
            end else begin
                hold_cnt_reg <= '0;
            end
        end
    end

    assign timeout = timeout_reg;
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    // grant_reg is only non-zero in GRANT, so this also masks writes in other states.
    assign load = |(wr_en & grant_reg);

    dff_en_reg #(
        .WIDTH (WIDTH)
    ) u_shared_reg (
        .clk   (clk),
        .reset (reset),
        .en    (load),
        .d     (wr_slice[owner_reg]),
        .q     (q)
    );

    assign grant   = grant_reg;
    assign owner   = owner_reg;
    assign busy    = |grant_reg;
    assign q_valid = q_valid_reg;

endmodule

// File: tb/tb_dff_arbiter.sv
// Directed and random checks of dff_arbiter against a transaction-level reference model.
module tb_dff_arbiter;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int TO = 16;
`ifdef DFF_ARB_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N-1:0]   wr_en = '0;
    logic [N*W-1:0] wr_data = '0;
    logic [N-1:0]   grant;
    logic [1:0]     owner;
    logic           busy;
    logic [W-1:0]   q;
    logic           q_valid;
    logic           timeout;

    int checks = 0;
    int passes = 0;

    // Reference model: who owns the register, who owned it last, gap cycle after release.
    int           m_owner;
    int           m_last;
    int           m_hold;
    bit           m_gap;
    bit           m_tmo;
    logic [W-1:0] m_q;
    bit           m_qv;

    always #5 clk = ~clk;

    dff_arbiter #(
        .N_REQ   (N),
        .WIDTH   (W),
        .TIMEOUT (TO)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .req     (req),
        .wr_en   (wr_en),
        .wr_data (wr_data),
        .grant   (grant),
        .owner   (owner),
        .busy    (busy),
        .q       (q),
        .q_valid (q_valid),
        .timeout (timeout)
    );

    function automatic void model_reset();
        m_owner = -1;
        m_last  = N - 1;
        m_hold  = 0;
        m_gap   = 1'b0;
        m_tmo   = 1'b0;
        m_q     = '0;
        m_qv    = 1'b0;
    endfunction

    function automatic void model_edge();
        m_tmo = 1'b0;
        if (m_owner >= 0) begin
            if (wr_en[m_owner]) begin
                m_q  = wr_data[m_owner*W +: W];
                m_qv = 1'b1;
            end
            m_hold++;
            if (!req[m_owner] || (TMO_EN && m_hold == TO)) begin
                m_tmo   = TMO_EN && (m_hold == TO);
                m_last  = m_owner;
                m_owner = -1;
                m_gap   = 1'b1;
            end
        end else if (m_gap) begin
            m_gap = 1'b0;
        end else if (req != '0) begin
            for (int k = 1; k <= N; k++) begin
                if (m_owner < 0 && req[(m_last + k) % N]) begin
                    m_owner = (m_last + k) % N;
                    m_hold  = 0;
                end
            end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=0x%0h expected=0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic check_all();
        logic [N-1:0] eg;
        eg = (m_owner >= 0) ? N'(1 << m_owner) : '0;
        check("grant", 32'(grant), 32'(eg));
        check("owner", 32'(owner), (m_owner >= 0) ? m_owner : 0);
        check("busy", 32'(busy), 32'(m_owner >= 0));
        check("q", 32'(q), 32'(m_q));
        check("q_valid", 32'(q_valid), 32'(m_qv));
        check("timeout", 32'(timeout), 32'(m_tmo));
        check("grant_onehot", 32'($countones(grant) <= 1), 32'd1);
    endtask

    task automatic step(input logic [N-1:0] r, input logic [N-1:0] w, input logic [N*W-1:0] d);
        @(negedge clk);
        req     = r;
        wr_en   = w;
        wr_data = d;
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        $display("t=%0t req=%b wr_en=%b grant=%b owner=%0d q=%h q_valid=%b timeout=%b",
                 $time, req, wr_en, grant, owner, q, q_valid, timeout);
    endtask

    initial begin
        int exp_order [5] = '{0, 1, 2, 3, 0};
        int ngr;
        int prev;
        logic [N-1:0]   r;
        logic [W-1:0]   q_before;

        // Reset state
        model_reset();
        #25;
        check_all();
        @(negedge clk);
        reset = 1'b1;

        // Round-robin order with 2-cycle holds, starting from requester 0
        ngr = 0;
        for (int c = 0; c < 60 && ngr < 5; c++) begin
            r = '1;
            if (m_owner >= 0 && m_hold >= 1) r[m_owner] = 1'b0;
            prev = m_owner;
            step(r, '0, '0);
            if (prev < 0 && m_owner >= 0) begin
                check("rr_order", 32'(owner), exp_order[ngr]);
                ngr++;
            end
        end
        check("rr_grant_count", ngr, 5);
        step('0, '0, '0);
        step('0, '0, '0);

        // Single requester write then release
        step(4'b0001, '0, '0);
        check("single_grant", 32'(grant), 32'b0001);
        step(4'b0001, 4'b0001, {24'h0, 8'hA5});
        step(4'b0000, '0, '0);
        check("single_q", 32'(q), 32'hA5);
        check("single_release_gap", 32'(grant), 32'b0000);
        step('0, '0, '0);

        // Write from a non-owner is ignored
        step(4'b0100, '0, '0);
        q_before = m_q;
        step(4'b0100, 4'b0010, {16'h0, 8'h3C, 8'h0});
        check("ignored_wr_q", 32'(q), 32'(q_before));
        check("ignored_wr_grant", 32'(grant), 32'b0100);
        // Owner write and release in the same cycle
        step(4'b0000, 4'b0100, {8'h0, 8'h5A, 16'h0});
        check("wr_and_drop_q", 32'(q), 32'h5A);
        step('0, '0, '0);

        // Reset mid-grant with a write pending
        step(4'b0001, '0, '0);
        @(negedge clk);
        wr_en   = 4'b0001;
        wr_data = {24'h0, 8'h77};
        #2 reset = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        req   = '0;
        wr_en = '0;
        reset = 1'b1;
        step('1, '0, '0);
        check("post_reset_owner", 32'(owner), 32'd0);
        check("post_reset_grant", 32'(grant), 32'b0001);
        step('0, '0, '0);
        step('0, '0, '0);

        // Long hold by requester 1, with requester 3 also waiting
        for (int c = 0; c < 100; c++) begin
            step(4'b1010, '0, '0);
        end
        step('0, '0, '0);
        step('0, '0, '0);
        step('0, '0, '0);

        // Random traffic
        for (int c = 0; c < 300; c++) begin
            r = N'($urandom);
            if (m_owner >= 0 && $urandom_range(0, 3) != 0) r[m_owner] = 1'b1;
            step(r, N'($urandom), {$urandom});
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
